// File: rtl/addatone_pkg.sv
// Shared types and helpers for the additive-synthesis harmonic accumulator.
// Latency: n/a (types, constants and a combinational saturation function only).
// Backpressure: n/a.
package addatone_pkg;

   localparam int          ACC_W_DEF     = 24;
   localparam int          OUT_SHIFT_DEF = 4;
   localparam logic [15:0] FULL_AMP      = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RDY,
      CAPTURE,
      MULT,
      ACCUM,
      GUARD,
      OUTPUT
   } state_e;

   // Clip a signed value into the signed 16-bit audio range.
   function automatic logic [15:0] saturate16(input logic signed [31:0] v);
      logic [15:0] r;
      if (v > 32'sd32767) begin
         r = 16'h7FFF;
      end else if (v < -32'sd32768) begin
         r = 16'h8000;
      end else begin
         r = 16'(v);
      end
      return r;
   endfunction

endpackage

// File: rtl/harmonic_level.sv
// Per-harmonic amplitude: restarts at full scale, scales by the rolloff ratio on each step.
// Latency: new amplitude visible one cycle after init_i/step_i.
// Backpressure: none; steps whenever step_i is asserted.
module harmonic_level
   import addatone_pkg::*;
(
   input  logic        i_Clock,
   input  logic        i_Reset_n,
   input  logic        init_i,
   input  logic        step_i,
   input  logic [15:0] rolloff_i,
   output logic [15:0] amp_o
);

   logic [15:0] amp_q;
   logic [15:0] amp_d;
   logic [31:0] prod;

   // Q0.16 x Q0.16 product; the upper half is the next amplitude.
   assign prod = amp_q * rolloff_i;

   // Next amplitude: init wins over step, otherwise hold.
   always_comb begin
      amp_d = amp_q;
      if (init_i) begin
         amp_d = FULL_AMP;
      end else if (step_i) begin
         amp_d = 16'(prod >> 16);
      end
   end

   // Amplitude register, full scale out of reset.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         amp_q <= FULL_AMP;
      end else begin
         amp_q <= amp_d;
      end
   end

   assign amp_o = amp_q;

endmodule

// File: rtl/harmonic_accumulator.sv
// Sums rolloff-scaled sine samples of all harmonics into one audio sample per trigger.
// Latency: per harmonic = wait for i_Sample_Ready + 4 cycles, then 1 cycle to o_Sample_Valid.
// Backpressure: stalls on i_Sample_Ready; triggers arriving while busy are dropped and flagged
// via o_Overrun. Optional ADDATONE_HARM_MASK_EN adds i_Harmonic_Mask (bit0 mutes even
// harmonics, bit1 mutes odd ones; handshake and amplitude stepping continue regardless).
module harmonic_accumulator
   import addatone_pkg::*;
#(
   parameter int ACC_W     = ACC_W_DEF,
   parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
   input  logic        i_Clock,
   input  logic        i_Reset_n,
   input  logic        i_Sample_Trigger,
   input  logic [7:0]  i_Harmonic_Count,
   input  logic [15:0] i_Rolloff,
   input  logic        i_Sample_Ready,
   input  logic [15:0] i_Sample_Value,
   input  logic        i_Freq_Too_High,
`ifdef ADDATONE_HARM_MASK_EN
   input  logic [1:0]  i_Harmonic_Mask,
`endif
   output logic [7:0]  o_Harmonic,
   output logic        o_Next_Sample,
   output logic [15:0] o_Sample_Out,
   output logic        o_Sample_Valid,
   output logic        o_Busy,
   output logic        o_Overrun
);

   state_e                   state_q, state_d;
   logic [7:0]               last_idx_q, last_idx_d;
   logic [7:0]               harm_q, harm_d;
   logic                     last_q, last_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [16:0]       term_q, term_d;
   logic                     next_q, next_d;
   logic [15:0]              out_q, out_d;
   logic                     valid_q, valid_d;
   logic                     busy_q, busy_d;
   logic                     overrun_q, overrun_d;

   logic                     amp_init;
   logic                     amp_step;
   logic [15:0]              amp;
   logic signed [32:0]       prod;
   logic                     term_mute;
   logic signed [31:0]       acc_ext;

   harmonic_level u_level (
      .i_Clock   (i_Clock),
      .i_Reset_n (i_Reset_n),
      .init_i    (amp_init),
      .step_i    (amp_step),
      .rolloff_i (i_Rolloff),
      .amp_o     (amp)
   );

   // Signed sample times unsigned amplitude; both operands widened so the product is exact.
   assign prod = $signed({{17{i_Sample_Value[15]}}, i_Sample_Value}) * $signed({17'b0, amp});

   // A term is muted above the Nyquist guard or, when masking is built in, by harmonic parity.
   always_comb begin
      term_mute = i_Freq_Too_High;
`ifdef ADDATONE_HARM_MASK_EN
      if ((i_Harmonic_Mask[0] && !harm_q[0]) || (i_Harmonic_Mask[1] && harm_q[0])) begin
         term_mute = 1'b1;
      end
`endif
   end

   // Accumulator scaled down for output, sign-extended to the saturation input width.
   assign acc_ext = $signed({{(32-ACC_W){acc_q[ACC_W-1]}}, acc_q}) >>> OUT_SHIFT;

   // Next-state and datapath control for one summation pass.
   always_comb begin
      state_d    = state_q;
      last_idx_d = last_idx_q;
      harm_d     = harm_q;
      last_d     = last_q;
      acc_d      = acc_q;
      term_d     = term_q;
      next_d     = 1'b0;
      out_d      = out_q;
      valid_d    = 1'b0;
      busy_d     = busy_q;
      overrun_d  = 1'b0;
      amp_init   = 1'b0;
      amp_step   = 1'b0;

      // Any state other than IDLE (including OUTPUT) is busy: the trigger is dropped.
      if (i_Sample_Trigger && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (i_Sample_Trigger) begin
               last_idx_d = (i_Harmonic_Count == 8'd0) ? 8'd0 : (i_Harmonic_Count - 8'd1);
               acc_d      = '0;
               harm_d     = 8'd0;
               last_d     = 1'b0;
               busy_d     = 1'b1;
               amp_init   = 1'b1;
               state_d    = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (i_Sample_Ready) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            // Generator's LUT output register settles during this cycle.
            state_d = MULT;
         end
         MULT: begin
            term_d  = term_mute ? 17'sd0 : 17'(prod >>> 16);
            state_d = ACCUM;
         end
         ACCUM: begin
            acc_d    = acc_q + {{(ACC_W-17){term_q[16]}}, term_q};
            amp_step = 1'b1;
            next_d   = 1'b1;
            // Wrap the index to 0 on the last harmonic so the generator reinitialises.
            if (harm_q == last_idx_q) begin
               harm_d = 8'd0;
               last_d = 1'b1;
            end else begin
               harm_d = harm_q + 8'd1;
               last_d = 1'b0;
            end
            state_d = GUARD;
         end
         GUARD: begin
            // Generator's ready is stale for one cycle after the consume pulse.
            state_d = last_q ? OUTPUT : WAIT_RDY;
         end
         OUTPUT: begin
            out_d   = saturate16(acc_ext);
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         last_idx_q <= 8'd0;
         harm_q     <= 8'd0;
         last_q     <= 1'b0;
         acc_q      <= '0;
         term_q     <= '0;
         next_q     <= 1'b0;
         out_q      <= 16'd0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         last_idx_q <= last_idx_d;
         harm_q     <= harm_d;
         last_q     <= last_d;
         acc_q      <= acc_d;
         term_q     <= term_d;
         next_q     <= next_d;
         out_q      <= out_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
      end
   end

   assign o_Harmonic     = harm_q;
   assign o_Next_Sample  = next_q;
   assign o_Sample_Out   = out_q;
   assign o_Sample_Valid = valid_q;
   assign o_Busy         = busy_q;
   assign o_Overrun      = overrun_q;

endmodule

// File: tb/tb_harmonic_accumulator.sv
// Bench for harmonic_accumulator: behavioural generator model plus arithmetic reference sum.
// Latency: n/a.
// Backpressure: generator model raises ready after a random 0..3 cycle delay.
`timescale 1ns/1ps
module tb_harmonic_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        trig = 1'b0;
   logic [7:0]  cnt = 8'd0;
   logic [15:0] roll = 16'd0;
   logic        rdy = 1'b0;
   logic [15:0] val = 16'd0;
   logic        fth = 1'b0;
`ifdef ADDATONE_HARM_MASK_EN
   logic [1:0]  mask = 2'b00;
`endif
   logic [7:0]  o_harm;
   logic        o_next;
   logic [15:0] o_out;
   logic        o_valid;
   logic        o_busy;
   logic        o_ovr;

   int checks = 0;
   int errors = 0;

   logic [15:0] samp [256];
   bit          fth_en = 1'b0;
   int          fth_thr = 0;
   int          next_cnt = 0;
   int          valid_cnt = 0;
   int          ovr_cnt = 0;
   int          dly = 0;
   bit          pend = 1'b0;

   harmonic_accumulator dut (
      .i_Clock          (clk),
      .i_Reset_n        (rst_n),
      .i_Sample_Trigger (trig),
      .i_Harmonic_Count (cnt),
      .i_Rolloff        (roll),
      .i_Sample_Ready   (rdy),
      .i_Sample_Value   (val),
      .i_Freq_Too_High  (fth),
`ifdef ADDATONE_HARM_MASK_EN
      .i_Harmonic_Mask  (mask),
`endif
      .o_Harmonic       (o_harm),
      .o_Next_Sample    (o_next),
      .o_Sample_Out     (o_out),
      .o_Sample_Valid   (o_valid),
      .o_Busy           (o_busy),
      .o_Overrun        (o_ovr)
   );

   always #5 clk = ~clk;

   // Sample-position generator model and pulse monitor, all on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (o_next)  next_cnt++;
         if (o_valid) valid_cnt++;
         if (o_ovr)   ovr_cnt++;
         if (!rst_n || o_next) begin
            rdy  = 1'b0;
            pend = 1'b0;
            dly  = $urandom_range(0, 3);
         end else if (!rdy) begin
            if (dly == 0) begin
               rdy  = 1'b1;
               pend = 1'b1;
               val  = 16'($urandom);   // not yet valid, one cycle after ready
            end else begin
               dly--;
            end
         end else begin
            pend = 1'b0;
            val  = samp[o_harm];
         end
         fth = fth_en && (int'(o_harm) >= fth_thr);
      end
   end

   // Reference: amplitude starts at 1.0 (FFFF), each term is floor(sample*amp/2^16),
   // amplitude becomes floor(amp*rolloff/2^16) after every harmonic.
   function automatic logic [15:0] model(input int n, input logic [15:0] r, input logic [1:0] m);
      longint acc, amp, s, t;
      int eff;
      acc = 0;
      amp = 65535;
      eff = (n == 0) ? 1 : n;
      for (int h = 0; h < eff; h++) begin
         s = longint'($signed(samp[h]));
         t = (s * amp) >>> 16;
         if (fth_en && h >= fth_thr) t = 0;
         if (m[0] && (h % 2 == 0))   t = 0;
         if (m[1] && (h % 2 == 1))   t = 0;
         acc = acc + t;
         amp = (amp * longint'(r)) >>> 16;
      end
      acc = acc >>> 4;
      if (acc > 32767)  return 16'h7FFF;
      if (acc < -32768) return 16'h8000;
      return 16'(acc);
   endfunction

   // Start a pass from a falling edge and wait (bounded) for its result.
   task automatic run_pass(input int n, input logic [15:0] r,
                           output logic [15:0] res, output bit timed_out);
      next_cnt  = 0;
      valid_cnt = 0;
      ovr_cnt   = 0;
      cnt  = 8'(n);
      roll = r;
      trig = 1'b1;
      @(negedge clk);
      trig = 1'b0;
      timed_out = 1'b1;
      res = 16'd0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (o_valid) begin
            res = o_out;
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic fill_const(input logic [15:0] v);
      for (int i = 0; i < 256; i++) samp[i] = v;
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 256; i++) samp[i] = 16'($urandom);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (o_out !== 16'd0)  begin errors++; $display("FAIL reset_out got %h want 0000", o_out); end
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_valid); end
      checks++; if (o_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
      checks++; if (o_harm !== 8'd0)  begin errors++; $display("FAIL reset_harm got %0d want 0", o_harm); end
      checks++; if (o_next !== 1'b0 || o_ovr !== 1'b0) begin
         errors++; $display("FAIL reset_pulses got next=%b ovr=%b want 0 0", o_next, o_ovr);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      logic [15:0] res; bit to;
      fill_const(16'h4000);
      run_pass(1, 16'h0000, res, to);
      checks++; if (to || res !== 16'h03FF) begin errors++; $display("FAIL single_out got %h to=%0d want 03ff", res, to); end
      checks++; if (next_cnt != 1) begin errors++; $display("FAIL single_next got %0d want 1", next_cnt); end
      checks++; if (o_harm !== 8'd0) begin errors++; $display("FAIL single_harm got %0d want 0", o_harm); end
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", o_busy); end
   endtask

   task automatic test_rolloff();
      logic [15:0] res; bit to; logic [15:0] exp;
      fill_const(16'h7FFF);
      exp = model(3, 16'h8000, 2'b00);
      run_pass(3, 16'h8000, res, to);
      checks++; if (to || res !== exp) begin errors++; $display("FAIL rolloff_out got %h want %h", res, exp); end
      checks++; if (next_cnt != 3) begin errors++; $display("FAIL rolloff_next got %0d want 3", next_cnt); end
   endtask

   task automatic test_full_count();
      logic [15:0] res; bit to;
      fill_const(16'h7FFF);
      run_pass(255, 16'hFFFF, res, to);
      checks++; if (to || res !== 16'h7FFF) begin errors++; $display("FAIL full_out got %h want 7fff", res); end
      checks++; if (next_cnt != 255) begin errors++; $display("FAIL full_next got %0d want 255", next_cnt); end
   endtask

   task automatic test_count_zero();
      logic [15:0] res; bit to; logic [15:0] exp;
      fill_rand();
      exp = model(0, 16'h9000, 2'b00);
      run_pass(0, 16'h9000, res, to);
      checks++; if (to || res !== exp) begin errors++; $display("FAIL zero_out got %h want %h", res, exp); end
      checks++; if (next_cnt != 1) begin errors++; $display("FAIL zero_next got %0d want 1", next_cnt); end
   endtask

   task automatic test_freq_guard();
      logic [15:0] res; bit to; logic [15:0] exp, r;
      fill_rand();
      r = 16'($urandom);
      fth_en = 1'b1;
      fth_thr = 2;
      exp = model(4, r, 2'b00);
      run_pass(4, r, res, to);
      checks++; if (to || res !== exp) begin errors++; $display("FAIL guard_out got %h want %h", res, exp); end
      checks++; if (next_cnt != 4) begin errors++; $display("FAIL guard_next got %0d want 4", next_cnt); end
      fth_en = 1'b0;
   endtask

   task automatic test_random();
      logic [15:0] res; bit to; logic [15:0] exp, r; int n;
      for (int k = 0; k < 8; k++) begin
         fill_rand();
         n = $urandom_range(1, 20);
         r = 16'($urandom);
         exp = model(n, r, 2'b00);
         run_pass(n, r, res, to);
         checks++; if (to || res !== exp) begin errors++; $display("FAIL random_out[%0d] got %h want %h", k, res, exp); end
         checks++; if (next_cnt != n) begin errors++; $display("FAIL random_next[%0d] got %0d want %0d", k, next_cnt, n); end
      end
   endtask

   task automatic test_overrun();
      logic [15:0] exp; bit seen;
      fill_rand();
      exp = model(6, 16'hE000, 2'b00);
      next_cnt = 0; valid_cnt = 0; ovr_cnt = 0;
      cnt = 8'd6; roll = 16'hE000;
      trig = 1'b1; @(negedge clk); trig = 1'b0;
      checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL ovr_busy got %b want 1", o_busy); end
      repeat (5) @(negedge clk);
      trig = 1'b1; @(negedge clk); trig = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (o_valid) begin
            seen = 1'b1;
            checks++; if (o_out !== exp) begin errors++; $display("FAIL ovr_out got %h want %h", o_out, exp); end
            break;
         end
      end
      if (!seen) begin checks++; errors++; $display("FAIL ovr_timeout got no valid want valid"); end
      repeat (20) @(negedge clk);
      checks++; if (ovr_cnt != 1)   begin errors++; $display("FAIL ovr_count got %0d want 1", ovr_cnt); end
      checks++; if (valid_cnt != 1) begin errors++; $display("FAIL ovr_valids got %0d want 1", valid_cnt); end
   endtask

   task automatic test_trigger_at_output();
      logic [15:0] exp; int k;
      fill_rand();
      exp = model(3, 16'hC000, 2'b00);
      cnt = 8'd3; roll = 16'hC000;
      trig = 1'b1; @(negedge clk); trig = 1'b0;
      k = 0;
      for (int i = 0; i < 2000 && k < 3; i++) begin
         @(negedge clk);
         if (o_next) k++;
      end
      checks++; if (k != 3) begin errors++; $display("FAIL edge_next got %0d want 3", k); end
      @(negedge clk);                 // OUTPUT cycle
      trig = 1'b1; @(negedge clk); trig = 1'b0;
      checks++; if (o_valid !== 1'b1 || o_out !== exp) begin
         errors++; $display("FAIL edge_out got valid=%b out=%h want 1 %h", o_valid, o_out, exp);
      end
      checks++; if (o_ovr !== 1'b1) begin errors++; $display("FAIL edge_overrun got %b want 1", o_ovr); end
      repeat (3) @(negedge clk);
      checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL edge_dropped got busy=%b want 0", o_busy); end
   endtask

   task automatic test_reset_midpass();
      logic [15:0] res; bit to; logic [15:0] exp;
      fill_const(16'h5000);
      cnt = 8'd20; roll = 16'hF000;
      trig = 1'b1; @(negedge clk); trig = 1'b0;
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (o_out !== 16'd0 || o_busy !== 1'b0 || o_harm !== 8'd0 || o_valid !== 1'b0 || o_next !== 1'b0) begin
         errors++; $display("FAIL midreset got out=%h busy=%b harm=%0d valid=%b next=%b want all 0",
                            o_out, o_busy, o_harm, o_valid, o_next);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      fill_rand();
      exp = model(5, 16'hA000, 2'b00);
      run_pass(5, 16'hA000, res, to);
      checks++; if (to || res !== exp) begin errors++; $display("FAIL recover_out got %h want %h", res, exp); end
   endtask

`ifdef ADDATONE_HARM_MASK_EN
   task automatic test_mask();
      logic [15:0] res; bit to; logic [15:0] exp;
      fill_const(16'h3000);
      mask = 2'b10;
      exp = model(4, 16'hC000, 2'b10);
      run_pass(4, 16'hC000, res, to);
      checks++; if (to || res !== exp) begin errors++; $display("FAIL mask_out got %h want %h", res, exp); end
      checks++; if (next_cnt != 4) begin errors++; $display("FAIL mask_next got %0d want 4", next_cnt); end
      mask = 2'b00;
   endtask
`endif

   initial begin
      fill_const(16'h0000);
      test_reset();
      test_single();
      test_rolloff();
      test_full_count();
      test_count_zero();
      test_freq_guard();
      test_random();
      test_overrun();
      test_trigger_at_output();
      test_reset_midpass();
`ifdef ADDATONE_HARM_MASK_EN
      test_mask();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
